// File: rtl/psum_acc_pkg.sv
// Shared types for psum_accumulator: FSM state enum and the saturating clip helper
// used by the lanes when PSUM_ACC_SAT_EN is defined.
package psum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int SAT_CALC_WIDTH = 64;

  // Clamp a wide signed sum into the signed range of a width-bit accumulator.
  function automatic logic signed [SAT_CALC_WIDTH-1:0] sat_clip(
    input logic signed [SAT_CALC_WIDTH-1:0] value,
    input int                               width
  );
    logic signed [SAT_CALC_WIDTH-1:0] max_val;
    logic signed [SAT_CALC_WIDTH-1:0] min_val;
    max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_val = -(64'sd1 <<< (width - 1));
    if (value > max_val) begin
      return max_val;
    end else if (value < min_val) begin
      return min_val;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Job control, partial-sum input stream and drain output stream of psum_accumulator.
// master drives jobs and psums (upstream/testbench); slave is the accumulator.
interface psum_accumulator_if #(
  parameter int PSUM_WIDTH   = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int ARRAY_HEIGHT = 4,
  parameter int ACC_DEPTH    = 16
);
  localparam int ADDR_WIDTH = $clog2(ACC_DEPTH);

  logic                               start;
  logic [ADDR_WIDTH:0]                num_vectors;
  logic [7:0]                         num_passes;
  logic                               psum_valid;
  logic [PSUM_WIDTH*ARRAY_HEIGHT-1:0] packed_psum_in;
  logic                               busy;
  logic                               done;
  logic                               out_valid;
  logic                               out_ready;
  logic [ACC_WIDTH*ARRAY_HEIGHT-1:0]  packed_acc_out;
  logic                               out_last;

  modport master (
    output start, num_vectors, num_passes, psum_valid, packed_psum_in, out_ready,
    input  busy, done, out_valid, packed_acc_out, out_last
  );

  modport slave (
    input  start, num_vectors, num_passes, psum_valid, packed_psum_in, out_ready,
    output busy, done, out_valid, packed_acc_out, out_last
  );

endinterface

// File: rtl/psum_acc_lane.sv
// One lane of the partial-sum buffer: ACC_DEPTH entries with overwrite (first pass) or
// accumulate (later passes); the add saturates when PSUM_ACC_SAT_EN is defined, else wraps.
module psum_acc_lane
  import psum_acc_pkg::*;
#(
  parameter int PSUM_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int ACC_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(ACC_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         first_pass,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic signed [PSUM_WIDTH-1:0] psum,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [ACC_WIDTH-1:0] mem [ACC_DEPTH];
  logic signed [ACC_WIDTH-1:0] psum_ext;
  logic signed [ACC_WIDTH-1:0] cur_val;
  logic signed [ACC_WIDTH-1:0] next_val;

  assign psum_ext = ACC_WIDTH'(psum);
  assign cur_val  = mem[wr_addr];

`ifdef PSUM_ACC_SAT_EN
  // One extra bit keeps the true sum so the clip sees real overflow.
  logic signed [ACC_WIDTH:0] sum_wide;
  assign sum_wide = (ACC_WIDTH+1)'(cur_val) + (ACC_WIDTH+1)'(psum_ext);
`endif

  always_comb begin
    next_val = psum_ext;
    if (!first_pass) begin
`ifdef PSUM_ACC_SAT_EN
      next_val = ACC_WIDTH'(sat_clip(SAT_CALC_WIDTH'(sum_wide), ACC_WIDTH));
`else
      next_val = cur_val + psum_ext;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ACC_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= next_val;
    end
  end

  assign acc = mem[rd_addr];

endmodule

// File: rtl/psum_accumulator.sv
// Multi-pass partial-sum accumulator behind the systolic array: accumulates N vectors over
// P passes, then drains them on a valid/ready stream. PSUM_ACC_SAT_EN selects saturating adds.
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int PSUM_WIDTH   = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int ARRAY_HEIGHT = 4,
  parameter int ACC_DEPTH    = 16
) (
  input logic                clk,
  input logic                rst,
  psum_accumulator_if.slave  bus
);

  localparam int ADDR_WIDTH = $clog2(ACC_DEPTH);
  localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(ACC_DEPTH);

  state_t                            state;
  state_t                            next_state;
  logic [CNT_WIDTH-1:0]              n_reg;
  logic [CNT_WIDTH-1:0]              n_clamped;
  logic [CNT_WIDTH-1:0]              n_last;
  logic [7:0]                        p_reg;
  logic [7:0]                        p_clamped;
  logic [7:0]                        pass_cnt;
  logic [ADDR_WIDTH-1:0]             wr_ptr;
  logic [ADDR_WIDTH-1:0]             rd_ptr;
  logic                              wr_en;
  logic                              handshake;
  logic                              wr_last;
  logic                              pass_last;
  logic                              rd_last;
  logic                              accum_done;
  logic                              drain_done;
  logic                              done_reg;
  logic                              first_pass;
  logic [ACC_WIDTH*ARRAY_HEIGHT-1:0] acc_word;

  always_comb begin
    n_clamped = bus.num_vectors;
    if (bus.num_vectors == '0) begin
      n_clamped = CNT_WIDTH'(1);
    end else if (bus.num_vectors > DEPTH_CNT) begin
      n_clamped = DEPTH_CNT;
    end
  end

  assign p_clamped  = (bus.num_passes == 8'd0) ? 8'd1 : bus.num_passes;
  assign n_last     = n_reg - CNT_WIDTH'(1);
  assign wr_last    = ({1'b0, wr_ptr} == n_last);
  assign pass_last  = (pass_cnt == p_reg - 8'd1);
  assign rd_last    = ({1'b0, rd_ptr} == n_last);
  assign first_pass = (pass_cnt == 8'd0);
  assign handshake  = (state == DRAIN) && bus.out_ready;
  assign accum_done = wr_en && wr_last && pass_last;
  assign drain_done = handshake && rd_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.start)  next_state = ACCUM;
      ACCUM:   if (accum_done) next_state = DRAIN;
      DRAIN:   if (drain_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    wr_en         = 1'b0;
    unique case (state)
      ACCUM: begin
        bus.busy = 1'b1;
        wr_en    = bus.psum_valid;
      end
      DRAIN: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Data outputs are forced to zero outside DRAIN so an aborted or idle job shows nothing.
  assign bus.out_last       = (state == DRAIN) && rd_last;
  assign bus.packed_acc_out = (state == DRAIN) ? acc_word : '0;
  assign bus.done           = done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg    <= '0;
      p_reg    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pass_cnt <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= drain_done;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            n_reg    <= n_clamped;
            p_reg    <= p_clamped;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pass_cnt <= '0;
          end
        end
        ACCUM: begin
          if (wr_en) begin
            if (wr_last) begin
              wr_ptr   <= '0;
              pass_cnt <= pass_cnt + 8'd1;
            end else begin
              wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (handshake) begin
            rd_ptr <= rd_last ? '0 : rd_ptr + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < ARRAY_HEIGHT; i++) begin : g_lane
    psum_acc_lane #(
      .PSUM_WIDTH (PSUM_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .ACC_DEPTH  (ACC_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .first_pass (first_pass),
      .wr_addr    (wr_ptr),
      .rd_addr    (rd_ptr),
      .psum       (bus.packed_psum_in[i*PSUM_WIDTH +: PSUM_WIDTH]),
      .acc        (acc_word[i*ACC_WIDTH +: ACC_WIDTH])
    );
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: directed jobs push hand-computed drain vectors into
// queues; monitors compare every valid drain cycle. A 16-bit instance covers PSUM_ACC_SAT_EN.
module tb_psum_accumulator;

  localparam int H  = 4;
  localparam int PW = 16;
  localparam int AW = 32;
  localparam int NW = 16;

  typedef struct {
    logic [AW*H-1:0] data;
    logic            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psum_accumulator_if #(.ACC_WIDTH(AW)) bus ();
  psum_accumulator_if #(.ACC_WIDTH(NW)) nbus ();

  psum_accumulator #(.ACC_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  psum_accumulator #(.ACC_WIDTH(NW)) dut_narrow (
    .clk (clk),
    .rst (rst),
    .bus (nbus.slave)
  );

  int              total = 0;
  int              bad   = 0;
  exp_t            exp_q[$];
  logic [NW*H-1:0] nexp_q[$];
  logic            pending_done = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, wanted %h", name, actual, expected);
    end
  endtask

  function automatic logic [AW*H-1:0] accLanes(input int v);
    logic [AW*H-1:0] r;
    for (int i = 0; i < H; i++) r[i*AW +: AW] = AW'(v * (i + 1));
    return r;
  endfunction

  function automatic logic [PW*H-1:0] psumLanes(input int v);
    logic [PW*H-1:0] r;
    for (int i = 0; i < H; i++) r[i*PW +: PW] = PW'(v * (i + 1));
    return r;
  endfunction

  function automatic logic [PW*H-1:0] psumFlat(input int v);
    logic [PW*H-1:0] r;
    for (int i = 0; i < H; i++) r[i*PW +: PW] = PW'(v);
    return r;
  endfunction

  function automatic logic [AW*H-1:0] accFlat(input int v);
    logic [AW*H-1:0] r;
    for (int i = 0; i < H; i++) r[i*AW +: AW] = AW'(v);
    return r;
  endfunction

  task automatic pushExp(input logic [AW*H-1:0] d, input logic last);
    exp_t e;
    e.data = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input int n, input int p);
    bus.start       = 1'b1;
    bus.num_vectors = 5'(n);
    bus.num_passes  = 8'(p);
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("busy_after_start", bus.busy, 1);
  endtask

  task automatic sendVec(input logic [PW*H-1:0] v);
    bus.psum_valid     = 1'b1;
    bus.packed_psum_in = v;
    @(posedge clk); #1;
    bus.psum_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int c = 0;
    while (bus.busy && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput("idle_reached", bus.busy, 0);
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  // Main monitor: done must pulse exactly one cycle after the last handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("done_pulse", bus.done, pending_done);
        if (pending_done) checkOutput("busy_with_done", bus.busy, 0);
        pending_done = 1'b0;
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_valid", bus.out_valid, 0);
          end else begin
            checkOutput("drain_data", bus.packed_acc_out, exp_q[0].data);
            checkOutput("drain_last", bus.out_last, exp_q[0].last);
            if (bus.out_ready) begin
              if (exp_q[0].last) pending_done = 1'b1;
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && nbus.out_valid) begin
        if (nexp_q.size() == 0) begin
          checkOutput("narrow_unexpected_valid", nbus.out_valid, 0);
        end else begin
          checkOutput("narrow_drain_data", nbus.packed_acc_out, nexp_q[0]);
          if (nbus.out_ready) void'(nexp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: bench did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    bus.start = 0; bus.num_vectors = '0; bus.num_passes = '0;
    bus.psum_valid = 0; bus.packed_psum_in = '0; bus.out_ready = 1;
    nbus.start = 0; nbus.num_vectors = '0; nbus.num_passes = '0;
    nbus.psum_valid = 0; nbus.packed_psum_in = '0; nbus.out_ready = 1;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_out_last", bus.out_last, 0);
    checkOutput("reset_acc_out", bus.packed_acc_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] job N=4 P=1 ascending vectors");
    for (int k = 0; k < 4; k++) pushExp(accFlat(k + 1), k == 3);
    applyStimulus(4, 1);
    for (int k = 0; k < 4; k++) sendVec(psumFlat(k + 1));
    waitIdle(20);

    $display("[TB] job N=2 P=3 negative psums");
    for (int k = 0; k < 2; k++) pushExp(accFlat(-15), k == 1);
    applyStimulus(2, 3);
    for (int k = 0; k < 6; k++) sendVec(psumFlat(-5));
    waitIdle(20);

    $display("[TB] job N=3 P=2 with out_ready stalls");
    pushExp(accLanes(11), 0);
    pushExp(accLanes(22), 0);
    pushExp(accLanes(33), 1);
    applyStimulus(3, 2);
    sendVec(psumLanes(10)); sendVec(psumLanes(20)); sendVec(psumLanes(30));
    sendVec(psumLanes(1));  sendVec(psumLanes(2));  sendVec(psumLanes(3));
    c = 0;
    while (bus.busy && c < 40) begin
      bus.out_ready = ((c % 4) == 0) || ((c % 4) == 3);
      @(posedge clk); #1;
      c++;
    end
    bus.out_ready = 1'b1;
    waitIdle(5);

    $display("[TB] start and psum during DRAIN are ignored");
    pushExp(accLanes(11), 0);
    pushExp(accLanes(22), 1);
    bus.out_ready = 1'b0;
    applyStimulus(2, 1);
    sendVec(psumLanes(11)); sendVec(psumLanes(22));
    bus.start = 1'b1; bus.num_vectors = 5'd3;
    bus.psum_valid = 1'b1; bus.packed_psum_in = psumLanes(99);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.psum_valid = 1'b0;
    checkOutput("busy_holds_in_drain", bus.busy, 1);
    bus.out_ready = 1'b1;
    waitIdle(10);

    $display("[TB] psum in IDLE dropped, N=0 clamps to 1, P=0 treated as 1");
    bus.psum_valid = 1'b1; bus.packed_psum_in = psumLanes(77);
    repeat (2) begin @(posedge clk); #1; end
    bus.psum_valid = 1'b0;
    checkOutput("idle_ignores_psum", bus.busy, 0);
    pushExp(accLanes(7), 1);
    bus.psum_valid = 1'b1; bus.packed_psum_in = psumLanes(55);
    applyStimulus(0, 0);
    bus.psum_valid = 1'b0;
    sendVec(psumLanes(7));
    waitIdle(10);

    $display("[TB] N=20 clamps to 16");
    for (int k = 0; k < 16; k++) pushExp(accFlat(100 + k), k == 15);
    applyStimulus(20, 1);
    for (int k = 0; k < 16; k++) sendVec(psumFlat(100 + k));
    waitIdle(40);

    $display("[TB] reset mid-ACCUM then fresh job");
    applyStimulus(8, 1);
    for (int k = 0; k < 5; k++) sendVec(psumFlat(9));
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_out_valid", bus.out_valid, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_acc_out", bus.packed_acc_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pushExp(accFlat(30), 0);
    pushExp(accFlat(40), 1);
    applyStimulus(2, 1);
    sendVec(psumFlat(30)); sendVec(psumFlat(40));
    waitIdle(10);

    $display("[TB] 16-bit accumulator overflow, N=1 P=4 psum=16384");
`ifdef PSUM_ACC_SAT_EN
    nexp_q.push_back(64'h7FFF_7FFF_7FFF_7FFF);
`else
    nexp_q.push_back(64'h0000_0000_0000_0000);
`endif
    nbus.start = 1'b1; nbus.num_vectors = 5'd1; nbus.num_passes = 8'd4;
    @(posedge clk); #1;
    nbus.start = 1'b0;
    repeat (4) begin
      nbus.psum_valid = 1'b1; nbus.packed_psum_in = psumFlat(16384);
      @(posedge clk); #1;
    end
    nbus.psum_valid = 1'b0;
    c = 0;
    while (nbus.busy && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput("narrow_idle", nbus.busy, 0);
    checkOutput("narrow_queue_drained", nexp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Downstream stage of the input-stationary systolic array: consumes the unskewed per-row partial-sum vectors it emits and accumulates them across multiple weight passes into a wider on-chip buffer. When all passes are complete, it drains the finished output vectors over a valid/ready stream. It lets a layer whose reduction dimension exceeds the array width be computed in several tiles without an external read-modify-write.

## Interface
- PSUM_WIDTH, 16: width of one incoming partial sum (signed)
- ACC_WIDTH, 32: width of one accumulator entry (signed, ≥ PSUM_WIDTH)
- ARRAY_HEIGHT, 4: lanes per vector (rows of the array)
- ACC_DEPTH, 16: accumulator buffer depth in vectors; ADDR_WIDTH = $clog2(ACC_DEPTH)
- Clock/reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle job start, honoured only in IDLE
- num_vectors  in  ADDR_WIDTH+1  vectors per pass N, sampled on start
- num_passes  in  8  passes P, sampled on start
- psum_valid  in  1  packed_psum_in holds a valid vector this cycle
- packed_psum_in  in  PSUM_WIDTH*ARRAY_HEIGHT  lane i at [i*PSUM_WIDTH +: PSUM_WIDTH]
- busy  out  1  high in ACCUM and DRAIN
- done  out  1  one-cycle pulse when the last vector is drained
- out_valid  out  1  drain data valid
- out_ready  in  1  downstream accepts
- packed_acc_out  out  ACC_WIDTH*ARRAY_HEIGHT  lane i at [i*ACC_WIDTH +: ACC_WIDTH]
- out_last  out  1  marks vector N-1 of the drain

## Operation
- FSM: IDLE → ACCUM on start; ACCUM → DRAIN when the N-th vector of pass P-1 is written; DRAIN → IDLE when vector N-1 handshakes (done pulses that cycle).
- Start latches N and P. N=0 → 1; N>ACC_DEPTH → ACC_DEPTH. P=0 → 1. wr_ptr, pass_cnt and rd_ptr are cleared.
- ACCUM: each psum_valid cycle updates entry wr_ptr, lane by lane.
  - Pass 0: entry = sign-extended psum (overwrite, no pre-clear needed).
  - Passes ≥1: entry = entry + sign-extended psum.
  - wr_ptr increments; at N-1 it wraps to 0 and pass_cnt increments.
- DRAIN: packed_acc_out = entry rd_ptr. rd_ptr advances on out_valid && out_ready. out_last = (rd_ptr == N-1).
- psum_valid outside ACCUM is dropped. start outside IDLE is ignored. Coincident start and psum_valid in IDLE: the job starts and the vector is dropped.

## Timing
- Reset values: state IDLE, busy 0, done 0, out_valid 0, out_last 0, packed_acc_out 0, all pointers/counters 0, buffer cleared to 0.
- Reset mid-operation aborts the job immediately. No partial drain follows.
- start at edge t → busy=1 from t+1. The first psum is accepted at t+1.
- Accumulate latency: 1 cycle, registered write at the accepting edge. Back-to-back psum_valid is supported every cycle, including the same entry on consecutive passes when N=1.
- Final psum accepted at edge t → out_valid=1 and entry 0 visible from t+1. No bubble is required between ACCUM and DRAIN.
- Drain throughput: 1 vector/cycle with out_ready held high. packed_acc_out and out_last hold stable while out_valid && !out_ready.
- Last handshake at edge t → done=1 during t+1, busy=0 and out_valid=0 from t+1. A new start is accepted the same cycle done is high.

## Configuration
- PSUM_ACC_SAT_EN defined: each lane add saturates to the signed ACC_WIDTH range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
- PSUM_ACC_SAT_EN undefined: two's-complement wrap-around, no overflow detection.

## Structure
- Shared package psum_acc_pkg: state enum (IDLE, ACCUM, DRAIN) and a saturating-add constant/function used under PSUM_ACC_SAT_EN.
- One sub-module: psum_acc_lane. It holds one lane's ACC_DEPTH×ACC_WIDTH storage plus the overwrite/add/saturate datapath, and is instantiated ARRAY_HEIGHT times.
- The top level owns the FSM, pointers, pass counter and output handshake.

## Test plan
- N=4, P=1, lanes fed 1,2,3,4 (vector k = k+1 on all lanes), out_ready=1 → drain 1,2,3,4, out_last on the 4th, done one cycle after.
- N=2, P=3, every psum = -5 → both drained entries = -15 on all lanes, sign-extended to 32 bits.
- N=3, P=2, out_ready toggling 1,0,0,1 → no vector lost or duplicated, data stable while stalled.
- PSUM_ACC_SAT_EN, ACC_WIDTH=16, N=1, P=4, psum=16384 → 32767 saturated. Without the macro → 0 (wrap).
- Assert rst mid-ACCUM after 5 vectors → all outputs 0 at once. A fresh start with N=2, P=1 drains only the new data.
- start during DRAIN, psum_valid during IDLE, N=0 and N=20 with ACC_DEPTH=16 → start and psum ignored. N is clamped to 1 and 16 respectively, seen as the drain length.
